// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - op-code values carried on alu_sel
//   - bit positions of the {N,Z,C,V} status flags
//   - FSM state encoding (ST_MUL is only used when ALU_SEQ_MUL_EN is defined)
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier (one partial product per clock).
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   load       capture a/b and perform the first iteration at this edge
//   a, b       operands (unsigned)
//   product    2*WIDTH-bit running / final product
//   last       high once all WIDTH partial products have been accumulated
// The load edge already adds partial product 0, so the product is complete
// WIDTH-1 edges after load; the caller consumes it on the following edge.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= CW'(WIDTH);   // idle: nothing left to do
    end else if (load) begin
      product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier  <= b >> 1;
      cnt     <= CW'(1);
    end else if (!last) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with latched operands, start/busy/done handshake,
// registered result + {N,Z,C,V} flags and a tristate bus driver.
// Build option: define ALU_SEQ_MUL_EN to enable the multi-cycle multiplier
// (op 7). Without it op 7 is a single-cycle op producing zero.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   alu_in1/2, alu_in1/2_en   operand data and per-operand load enables
//   alu_sel                   op code, sampled together with start
//   start                     request; accepted whenever the FSM is idle
//   out_en                    allow result/flags to update on completion
//   bus_tri_en                drive out_to_bus from alu_result
//   busy                      multiply in progress (start ignored)
//   done                      one-cycle completion strobe
//   alu_result, flags         registered result and {N,Z,C,V}
//   out_to_bus                alu_result or all Z
// Handshake: start is sampled at each rising edge while not busy; the op then
// completes at that edge (single-cycle ops) or WIDTH edges later (multiply),
// and done is high for exactly the cycle after the completing edge. A start
// in the done cycle is a new, accepted request.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  input  logic             alu_in1_en,
  input  logic             alu_in2_en,
  input  logic [2:0]       alu_sel,
  input  logic             start,
  input  logic             out_en,
  input  logic             bus_tri_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] out_to_bus
);

  localparam int MSB = WIDTH - 1;

  if (MUL_CYCLES != WIDTH) begin : g_cfg_check
    $error("alu_seq: MUL_CYCLES must equal WIDTH");
  end

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  logic             fin;        // an op completes at this edge
  logic [WIDTH-1:0] fin_res;
  logic [3:0]       fin_flags;

  // Operand registers: load in any state; a same-edge start still sees the
  // old value because the datapath reads the register outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            op_a <= '0;
    else if (alu_in1_en) op_a <= alu_in1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            op_b <= '0;
    else if (alu_in2_en) op_b <= alu_in2;
  end

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};   // top bit = borrow

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        alu_res = add_full[MSB:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_full[MSB:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[MSB-1:0], 1'b0};
        alu_c   = op_a[MSB];
      end
      default: ;   // OP_MUL on the single-cycle path yields zero
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

`ifdef ALU_SEQ_MUL_EN
  state_t               state, state_nx;
  logic                 mul_load;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 mul_last;
  logic [3:0]           mul_flags;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (op_a),
    .b       (op_b),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[MSB];
    mul_flags[FLAG_Z] = (mul_product[MSB:0] == '0);
    mul_flags[FLAG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_load  = 1'b0;
    fin       = 1'b0;
    fin_res   = alu_res;
    fin_flags = alu_flags;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (alu_sel == OP_MUL) begin
            state_nx = ST_MUL;
            mul_load = 1'b1;
          end else begin
            fin = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // start is deliberately ignored here
        if (mul_last) begin
          state_nx  = ST_IDLE;
          fin       = 1'b1;
          fin_res   = mul_product[MSB:0];
          fin_flags = mul_flags;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_MUL);
`else
  always_comb begin
    fin       = start;
    fin_res   = alu_res;
    fin_flags = alu_flags;
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done       <= 1'b0;
      alu_result <= '0;
      flags      <= '0;
    end else begin
      done <= fin;
      if (fin && out_en) begin
        alu_result <= fin_res;
        flags      <= fin_flags;
      end
    end
  end

  assign out_to_bus = bus_tri_en ? alu_result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16). Expected results
// come from an arithmetic reference model and flow through an expected queue.
module tb_alu_seq;

  localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] alu_in1, alu_in2;
  logic         alu_in1_en, alu_in2_en;
  logic [2:0]   alu_sel;
  logic         start, out_en, bus_tri_en;
  logic         busy, done;
  logic [W-1:0] alu_result;
  logic [3:0]   flags;
  logic [W-1:0] out_to_bus;

  int total = 0;
  int bad   = 0;

  logic [W+3:0] exp_q[$];     // {flags, result} per completion
  logic [W-1:0] a_reg, b_reg; // model of the operand registers
  logic [W-1:0] exp_res;
  logic [3:0]   exp_flags;

  alu_seq #(.WIDTH(W), .MUL_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_in1_en (alu_in1_en),
    .alu_in2_en (alu_in2_en),
    .alu_sel    (alu_sel),
    .start      (start),
    .out_en     (out_en),
    .bus_tri_en (bus_tri_en),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .flags      (flags),
    .out_to_bus (out_to_bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: {N,Z,C,V, result} from plain integer arithmetic.
  function automatic logic [W+3:0] ref_op(input logic [2:0] sel,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint m, ua, ub, sa, sb, full, r, sr;
    bit c, v, n, z;
    m  = 64'sd1 << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    c = 1'b0; v = 1'b0; r = 0;
    case (sel)
      3'd0: begin full = ua + ub; r = full % m; c = (full >= m);
                  sr = sa + sb; v = (sr >= m / 2) || (sr < -(m / 2)); end
      3'd1: begin full = ua - ub; r = (full + m) % m; c = (ua < ub);
                  sr = sa - sb; v = (sr >= m / 2) || (sr < -(m / 2)); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (m - 1) - ua;
      3'd6: begin full = ua * 2; r = full % m; c = (full >= m); end
      default: begin
        if (MUL_EN) begin full = ua * ub; r = full % m; c = (full >= m); end
        else r = 0;
      end
    endcase
    n = (r >= m / 2);
    z = (r == 0);
    return {n, z, c, v, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    alu_in1 = a; alu_in2 = b; alu_in1_en = 1'b1; alu_in2_en = 1'b1;
    @(negedge clk);
    alu_in1_en = 1'b0; alu_in2_en = 1'b0;
    a_reg = a; b_reg = b;
  endtask

  // Start one op, optionally loading new operands at the same edge, then wait
  // (bounded) for done and score it.
  task automatic run_op(input logic [2:0] sel, input logic oe, input logic ld,
                        input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W+3:0] e;
    int  lat, exp_lat;
    bit  seen;
    e = ref_op(sel, a_reg, b_reg);
    exp_lat = (MUL_EN && sel == 3'd7) ? W + 1 : 1;
    if (oe) exp_q.push_back(e);
    else    exp_q.push_back({exp_flags, exp_res});
    alu_sel = sel; start = 1'b1; out_en = oe;
    if (ld) begin
      alu_in1 = na; alu_in2 = nb; alu_in1_en = 1'b1; alu_in2_en = 1'b1;
      a_reg = na; b_reg = nb;
    end
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      start = 1'b0; alu_in1_en = 1'b0; alu_in2_en = 1'b0;
      if (done) seen = 1'b1;
      else begin
        check("busy_during_op", {31'd0, busy}, {31'd0, exp_lat > 1});
        if (exp_lat > 1 && $urandom_range(0, 2) == 0) begin
          start = 1'b1;                       // must be ignored while busy
          alu_sel = 3'($urandom_range(0, 6));
        end
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("latency", lat, exp_lat);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("result", {16'd0, alu_result}, {16'd0, e[W-1:0]});
      check("flags", {28'd0, flags}, {28'd0, e[W+3:W]});
      exp_res = e[W-1:0];
      exp_flags = e[W+3:W];
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] basic_tbl [7];
    logic [W-1:0] zz;
    logic [W+3:0] e;
    bit any_done;
    basic_tbl = '{16'h0076, 16'h0022, 16'h0008, 16'h006E, 16'h0066, 16'hFFB3, 16'h0098};
    zz = 'z;

    rst = 1'b0; alu_in1 = '0; alu_in2 = '0; alu_in1_en = 1'b0; alu_in2_en = 1'b0;
    alu_sel = '0; start = 1'b0; out_en = 1'b1; bus_tri_en = 1'b1;
    a_reg = '0; b_reg = '0; exp_res = '0; exp_flags = '0;
    repeat (2) @(negedge clk);
    check("rst_result", {16'd0, alu_result}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bus", {16'd0, out_to_bus}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic ops back to back, one per clock.
    load_ops(16'h004C, 16'h002A);
    for (int k = 0; k < 7; k++) begin
      alu_sel = 3'(k); start = 1'b1; out_en = 1'b1;
      @(negedge clk);
      e = ref_op(3'(k), a_reg, b_reg);
      check("b2b_done", {31'd0, done}, 32'd1);
      check("b2b_result", {16'd0, alu_result}, {16'd0, basic_tbl[k]});
      check("b2b_flags", {28'd0, flags}, {28'd0, e[W+3:W]});
      exp_res = e[W-1:0]; exp_flags = e[W+3:W];
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_end", {31'd0, done}, 32'd0);

    // Operand enable off: input change is not captured.
    alu_in1 = '0;
    run_op(3'd0, 1'b1, 1'b0, '0, '0);
    check("in1_en_hold", {16'd0, alu_result}, 32'h0076);
    // out_en off: done pulses, result holds.
    run_op(3'd1, 1'b0, 1'b0, '0, '0);
    check("out_en_hold", {16'd0, alu_result}, 32'h0076);
    // Tristate bus.
    bus_tri_en = 1'b0;
    #1 check("bus_z", {16'd0, out_to_bus}, {16'd0, zz});
    bus_tri_en = 1'b1;
    #1 check("bus_drive", {16'd0, out_to_bus}, 32'h0076);
    @(negedge clk);

    // Flag corners.
    load_ops(16'hFFFF, 16'h0001);
    run_op(3'd0, 1'b1, 1'b0, '0, '0);
    check("add_wrap_res", {16'd0, alu_result}, 32'h0000);
    check("add_wrap_flags", {28'd0, flags}, 32'h6);
    load_ops(16'h8000, 16'h0001);
    run_op(3'd1, 1'b1, 1'b0, '0, '0);
    check("sub_ovf_res", {16'd0, alu_result}, 32'h7FFF);
    check("sub_ovf_flags", {28'd0, flags}, 32'h1);
    load_ops(16'h0001, 16'h0002);
    run_op(3'd1, 1'b1, 1'b0, '0, '0);
    check("sub_borrow_res", {16'd0, alu_result}, 32'hFFFF);
    check("sub_borrow_flags", {28'd0, flags}, 32'hA);

    // Multiply (or single-cycle zero without the multiplier).
    load_ops(16'h004C, 16'h002A);
    run_op(3'd7, 1'b1, 1'b0, '0, '0);
    check("mul_res", {16'd0, alu_result}, MUL_EN ? 32'h0C78 : 32'h0000);
    check("mul_flags", {28'd0, flags}, MUL_EN ? 32'h0 : 32'h4);
    load_ops(16'h0100, 16'h0100);
    run_op(3'd7, 1'b1, 1'b0, '0, '0);
    check("mul_ovf_res", {16'd0, alu_result}, 32'h0000);
    check("mul_ovf_flags", {28'd0, flags}, MUL_EN ? 32'h6 : 32'h4);

    // Randomized ops, with same-edge operand loads and out_en gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) load_ops(pick_operand(), pick_operand());
      run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 2) == 0), pick_operand(), pick_operand());
    end

    // Reset in the middle of a multiply.
    load_ops(16'h1234, 16'h0077);
    alu_sel = 3'd7; start = 1'b1; out_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", {16'd0, alu_result}, 32'd0);
    check("midrst_flags", {28'd0, flags}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    a_reg = '0; b_reg = '0; exp_res = '0; exp_flags = '0;
    any_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) any_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, any_done}, 32'd0);
    load_ops(16'h0005, 16'h0009);
    run_op(3'd0, 1'b1, 1'b0, '0, '0);
    check("post_rst_add", {16'd0, alu_result}, 32'h000E);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
